// File: rtl/buttons_controller.sv
// Push-button input controller for the Zybo-Z7 board.
// Synchronises and debounces the four buttons, latches press events and
// presents {events, levels} on the CPU port/SFR read path. o_irq is raised
// while any press event is waiting to be read.
module buttons_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_rd,
  input  logic [3:0] i_btn,
  output logic [7:0] o_data,
  output logic       o_irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       level;
  logic [3:0]       level_nx;
  logic [3:0]       evt;
  logic [3:0]       evt_nx;
  logic [3:0]       press;
  logic [CNT_W-1:0] cnt    [4];
  logic [CNT_W-1:0] cnt_nx [4];

  // Debounce: count consecutive cycles the synced pin disagrees with the
  // accepted level; any agreement restarts the count, and reaching the
  // limit accepts the new level and returns the counter to zero.
  always_comb begin
    level_nx = level;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_nx[i] = '0;
      if (sync2[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_nx[i] = sync2[i];
        end else begin
          cnt_nx[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Event latch: a read clears all pending bits, but a press accepted on the
  // same edge is OR-ed in afterwards so it survives the clear.
  always_comb begin
    press  = level_nx & ~level & {4{i_en}};
    evt_nx = (i_rd ? 4'b0000 : evt) | press;
  end

  // State registers: two-stage synchroniser, counters, levels and events.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      evt   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
      level <= level_nx;
      evt   <= evt_nx;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= cnt_nx[i];
      end
    end
  end

  assign o_data = {evt, level};
  assign o_irq  = |evt;

endmodule
